// File: rtl/ahb_lite_master.sv
// AHB-Lite single-initiator master: turns a valid/ready command stream into pipelined
// NONSEQ single transfers and reports each completion on a one-cycle response strobe.
module ahb_lite_master #(
    parameter int unsigned AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_size,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic          rsp_err,
    output logic [31:0]   rsp_rdata,
    output logic          HSEL,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    input  logic [31:0]   HRDATA,
    output logic          busy
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Address-phase stage
    logic          r_a_valid;
    logic [AW-1:0] r_a_addr;
    logic          r_a_write;
    logic [1:0]    r_a_size;
    logic [31:0]   r_a_wdata;

    // Data-phase stage
    logic          r_d_valid;
    logic          r_d_write;
    logic [1:0]    r_d_size;
    logic [1:0]    r_d_lsb;
    logic [31:0]   r_d_wdata;

    logic          r_cancel;
    logic          r_rsp_valid;
    logic          r_rsp_write;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    logic          w_accept;
    logic [1:0]    w_cmd_size;
    logic [AW-1:0] w_cmd_addr;
    logic [31:0]   w_cmd_wdata;
    logic [31:0]   w_rdata_lane;

    assign cmd_ready = HRESETn && !r_cancel && !(HRESP && !HREADY) && (!r_a_valid || HREADY);
    assign w_accept  = cmd_valid && cmd_ready;

    // Size 3 is carried as a word so HSIZE never advertises a transfer wider than the bus.
    always_comb begin
        w_cmd_size  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        w_cmd_addr  = cmd_addr;
        w_cmd_wdata = cmd_wdata;
        case (w_cmd_size)
            2'd0: begin
                w_cmd_wdata = {4{cmd_wdata[7:0]}};
            end
            2'd1: begin
                w_cmd_addr  = {cmd_addr[AW-1:1], 1'b0};
                w_cmd_wdata = {2{cmd_wdata[15:0]}};
            end
            default: begin
                w_cmd_addr  = {cmd_addr[AW-1:2], 2'b00};
            end
        endcase
    end

    always_comb begin
        w_rdata_lane = HRDATA;
        case (r_d_size)
            2'd0:    w_rdata_lane = {24'h0, HRDATA[{r_d_lsb, 3'b000} +: 8]};
            2'd1:    w_rdata_lane = r_d_lsb[1] ? {16'h0, HRDATA[31:16]} : {16'h0, HRDATA[15:0]};
            default: w_rdata_lane = HRDATA;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_a_valid   <= 1'b0;
            r_a_addr    <= '0;
            r_a_write   <= 1'b0;
            r_a_size    <= 2'd0;
            r_a_wdata   <= 32'h0;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_size    <= 2'd0;
            r_d_lsb     <= 2'd0;
            r_d_wdata   <= 32'h0;
            r_cancel    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_d_valid && HREADY) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= HRESP;
                r_rsp_write <= r_d_write;
                r_rsp_rdata <= r_d_write ? 32'h0 : w_rdata_lane;
            end

            if (HREADY) begin
                if (r_cancel) begin
                    // Second ERROR cycle: the address phase was IDLE, A is kept for re-issue.
                    r_d_valid <= 1'b0;
                    r_cancel  <= 1'b0;
                end else begin
                    r_d_valid <= r_a_valid;
                    if (r_a_valid) begin
                        r_d_write <= r_a_write;
                        r_d_size  <= r_a_size;
                        r_d_lsb   <= r_a_addr[1:0];
                        r_d_wdata <= r_a_wdata;
                    end
                    if (!w_accept) begin
                        r_a_valid <= 1'b0;
                    end
                end
            end else if (HRESP && r_d_valid) begin
                r_cancel <= 1'b1;
            end

            if (w_accept) begin
                r_a_valid <= 1'b1;
                r_a_addr  <= w_cmd_addr;
                r_a_write <= cmd_write;
                r_a_size  <= w_cmd_size;
                r_a_wdata <= w_cmd_wdata;
            end
        end
    end

    assign HTRANS    = (r_a_valid && !r_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSEL      = HTRANS[1];
    assign HADDR     = r_a_addr;
    assign HWRITE    = r_a_write;
    assign HSIZE     = {1'b0, r_a_size};
    assign HWDATA    = r_d_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = HRESETn && (r_a_valid || r_d_valid);

endmodule
